// File: rtl/brom_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// brom_arbiter: round-robin two-port boot ROM arbiter with alignment, range
//               and response-timeout faulting.            Revision: 1.0
// -----------------------------------------------------------------------------
module brom_arbiter #(
  parameter int ROM_WORDS = 401,
  parameter int TIMEOUT   = 15
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_p0_request,
  input  logic [31:0] i_p0_address,
  output logic [31:0] o_p0_rdata,
  output logic        o_p0_ready,
  output logic        o_p0_fault,
  input  logic        i_p1_request,
  input  logic [31:0] i_p1_address,
  output logic [31:0] o_p1_rdata,
  output logic        o_p1_ready,
  output logic        o_p1_fault,
  output logic        o_brom_request,
  output logic [31:0] o_brom_address,
  input  logic [31:0] i_brom_rdata,
  input  logic        i_brom_ready
);

  localparam int               CNT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [31:0]      ROM_LIMIT = 32'(ROM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic             port_q, port_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             brom_req_q, brom_req_d;
  logic [31:0]      brom_addr_q, brom_addr_d;
  logic [1:0]       ready_q, ready_d;
  logic [1:0]       fault_q, fault_d;
  logic [1:0][31:0] rdata_q, rdata_d;

  logic [1:0]  req;
  logic [1:0]  elig;
  logic        gnt;
  logic [31:0] gnt_addr;
  logic        gnt_bad;

  // A port whose ready is showing this cycle is still holding the old request.
  assign req      = {i_p1_request, i_p0_request};
  assign elig     = req & ~ready_q;
  assign gnt      = (elig == 2'b11) ? ~last_q : elig[1];
  assign gnt_addr = gnt ? i_p1_address : i_p0_address;
  assign gnt_bad  = (gnt_addr[1:0] != 2'b00) || ({2'b00, gnt_addr[31:2]} >= ROM_LIMIT);

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    brom_req_d  = 1'b0;
    brom_addr_d = brom_addr_q;
    ready_d     = 2'b00;
    fault_d     = 2'b00;
    rdata_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (elig != 2'b00) begin
          last_d = gnt;
          port_d = gnt;
          if (gnt_bad) begin
            ready_d[gnt] = 1'b1;
            fault_d[gnt] = 1'b1;
          end else begin
            state_d     = S_ISSUE;
            brom_req_d  = 1'b1;
            brom_addr_d = gnt_addr;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
        cnt_d   = '0;
      end
      S_WAIT: begin
        if (i_brom_ready) begin
          state_d          = S_IDLE;
          ready_d[port_q]  = 1'b1;
          rdata_d[port_q]  = i_brom_rdata;
        end else if (cnt_q == CNT_LAST) begin
          state_d          = S_IDLE;
          ready_d[port_q]  = 1'b1;
          fault_d[port_q]  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      port_q      <= 1'b0;
      cnt_q       <= '0;
      brom_req_q  <= 1'b0;
      brom_addr_q <= '0;
      ready_q     <= 2'b00;
      fault_q     <= 2'b00;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      port_q      <= port_d;
      cnt_q       <= cnt_d;
      brom_req_q  <= brom_req_d;
      brom_addr_q <= brom_addr_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
    end
  end

  assign o_p0_rdata     = rdata_q[0];
  assign o_p0_ready     = ready_q[0];
  assign o_p0_fault     = fault_q[0];
  assign o_p1_rdata     = rdata_q[1];
  assign o_p1_ready     = ready_q[1];
  assign o_p1_fault     = fault_q[1];
  assign o_brom_request = brom_req_q;
  assign o_brom_address = brom_addr_q;

endmodule
`default_nettype wire
